irq_prio_ctrl_32: RTL and testbench

//  Interrupt controller for the 32-line interrupt fan-in bus of the SoC.

---
 rtl/irq_prio_ctrl_32_if.sv | 38 +++
 rtl/irq_prio_ctrl_32.sv | 137 +++++++++++++
 tb/tb_irq_prio_ctrl_32.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_prio_ctrl_32_if.sv
// rtl/irq_prio_ctrl_32_if.sv - core-side and source-side signal bundle of the 32-line interrupt controller
//
// Signals:
//   irq_in[31:0]      raw interrupt lines, bit i = source i
//   irq_enable[31:0]  per-line enable
//   irq_edge[31:0]    per-line mode, 1 = rising edge, 0 = level high
//   claim             core pulse accepting the presented irq_id
//   complete          core pulse ending service of complete_id
//   complete_id[4:0]  ID being completed
//   irq_req           interrupt request to the core
//   irq_id[4:0]       ID of the requested / in-service line
//   busy              a line is in service
//   pending_o[31:0]   current pending vector
//   complete_err      one-cycle pulse on a bad complete
// Modports: master drives the inputs (sources + core), slave is the controller.
interface irq_prio_ctrl_32_if;
   logic [31:0] irq_in;
   logic [31:0] irq_enable;
   logic [31:0] irq_edge;
   logic        claim;
   logic        complete;
   logic [4:0]  complete_id;
   logic        irq_req;
   logic [4:0]  irq_id;
   logic        busy;
   logic [31:0] pending_o;
   logic        complete_err;

   modport master (
      output irq_in, irq_enable, irq_edge, claim, complete, complete_id,
      input  irq_req, irq_id, busy, pending_o, complete_err
   );

   modport slave (
      input  irq_in, irq_enable, irq_edge, claim, complete, complete_id,
      output irq_req, irq_id, busy, pending_o, complete_err
   );
endinterface

// File: rtl/irq_prio_ctrl_32.sv
// rtl/irq_prio_ctrl_32.sv - 32-line fixed-priority interrupt controller with claim/complete handshake
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    irq_prio_ctrl_32_if.slave (lines, enables, modes, claim/complete, request outputs)
// Option macro: IRQ_SYNC_EN - when defined, irq_in passes a 2-flop synchronizer
//   before edge/level detection (adds 2 cycles to every input-to-request path).
module irq_prio_ctrl_32 (
   input  logic               clk,
   input  logic               rst_n,
   irq_prio_ctrl_32_if.slave  bus
);

   localparam int IRQ_NUM = 32;
   localparam int ID_W    = 5;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [IRQ_NUM-1:0]  w_irq_s;
   logic [IRQ_NUM-1:0]  r_prev;
   logic [IRQ_NUM-1:0]  r_pending;
   logic [ID_W-1:0]     r_irq_id;
   logic                r_irq_req;
   logic                r_busy;
   logic                r_complete_err;

   logic [IRQ_NUM-1:0]  w_rise;
   logic [IRQ_NUM-1:0]  w_busy_mask;
   logic [IRQ_NUM-1:0]  w_set;
   logic [IRQ_NUM-1:0]  w_clr;
   logic [IRQ_NUM-1:0]  w_active;
   logic [ID_W-1:0]     w_win_id;
   logic                w_latch;
   logic                w_claim_ok;
   logic                w_cmp_ok;

`ifdef IRQ_SYNC_EN
   logic [IRQ_NUM-1:0]  r_sync1;
   logic [IRQ_NUM-1:0]  r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.irq_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_s = r_sync2;
`else
   assign w_irq_s = bus.irq_in;
`endif

   assign w_rise = w_irq_s & ~r_prev;

   // The line currently in service may not re-pend until it is completed.
   assign w_busy_mask = r_busy ? (32'd1 << r_irq_id) : '0;

   assign w_set = bus.irq_enable
                & ((bus.irq_edge & w_rise) | (~bus.irq_edge & w_irq_s))
                & ~w_busy_mask;

   assign w_claim_ok = (r_state == S_ASSERT) && bus.claim;
   assign w_clr      = w_claim_ok ? (32'd1 << r_irq_id) : '0;
   assign w_cmp_ok   = (r_state == S_SERVICE) && bus.complete
                     && (bus.complete_id == r_irq_id);

   assign w_active = r_pending & bus.irq_enable;
   assign w_latch  = (r_state == S_IDLE) && (|w_active);

   // Scan high to low so the lowest active index is the last one written.
   always_comb begin
      w_win_id = '0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (w_active[i]) w_win_id = ID_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (|w_active) w_next = S_ASSERT;
         end
         S_ASSERT: begin
            // Claim beats a same-cycle enable drop; the core already took the ID.
            if (bus.claim)                        w_next = S_SERVICE;
            else if (!bus.irq_enable[r_irq_id])   w_next = S_IDLE;
         end
         S_SERVICE: begin
            if (w_cmp_ok) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev         <= '0;
         r_pending      <= '0;
         r_irq_id       <= '0;
         r_irq_req      <= 1'b0;
         r_busy         <= 1'b0;
         r_complete_err <= 1'b0;
      end else begin
         r_prev         <= w_irq_s;
         // Set after clear: a fresh request in the claim cycle survives.
         r_pending      <= (r_pending & ~w_clr) | w_set;
         if (w_latch) r_irq_id <= w_win_id;
         r_irq_req      <= (w_next == S_ASSERT);
         r_busy         <= (w_next == S_SERVICE);
         r_complete_err <= bus.complete & ~w_cmp_ok;
      end
   end

   assign bus.irq_req      = r_irq_req;
   assign bus.irq_id       = r_irq_id;
   assign bus.busy         = r_busy;
   assign bus.pending_o    = r_pending;
   assign bus.complete_err = r_complete_err;

endmodule

// File: tb/tb_irq_prio_ctrl_32.sv
// tb/tb_irq_prio_ctrl_32.sv - self-checking bench for irq_prio_ctrl_32
module tb_irq_prio_ctrl_32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   irq_prio_ctrl_32_if bus_if ();

   irq_prio_ctrl_32 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

`ifdef IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam logic [31:0] EDG = 32'hFFFF_FFFE;   // line 0 level, all others edge
   localparam logic [31:0] ALL = 32'hFFFF_FFFF;
   localparam logic [31:0] NO0 = 32'hFFFF_FFFE;

   typedef struct {
      logic [31:0] in;
      logic [31:0] en;
      logic        claim;
      logic        cmp;
      logic [4:0]  cid;
      logic        req;
      logic [4:0]  id;
      logic        busy;
      logic [31:0] pend;
      logic        err;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void add(input logic [31:0] in, input logic [31:0] en,
                               input logic claim, input logic cmp, input logic [4:0] cid,
                               input logic req, input logic [4:0] id, input logic busy,
                               input logic [31:0] pend, input logic err);
      vec_t v;
      v.in = in; v.en = en; v.claim = claim; v.cmp = cmp; v.cid = cid;
      v.req = req; v.id = id; v.busy = busy; v.pend = pend; v.err = err;
      tbl.push_back(v);
   endfunction

   function automatic vec_t mk(input logic [31:0] in, input logic [31:0] en,
                               input logic claim, input logic cmp, input logic [4:0] cid,
                               input logic req, input logic [4:0] id, input logic busy,
                               input logic [31:0] pend, input logic err);
      vec_t v;
      v.in = in; v.en = en; v.claim = claim; v.cmp = cmp; v.cid = cid;
      v.req = req; v.id = id; v.busy = busy; v.pend = pend; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      bus_if.irq_in      = v.in;
      bus_if.irq_enable  = v.en;
      bus_if.irq_edge    = EDG;
      bus_if.claim       = v.claim;
      bus_if.complete    = v.cmp;
      bus_if.complete_id = v.cid;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, " irq_req"},      {31'd0, bus_if.irq_req},      {31'd0, e.req});
      chk({tag, " irq_id"},       {27'd0, bus_if.irq_id},       {27'd0, e.id});
      chk({tag, " busy"},         {31'd0, bus_if.busy},         {31'd0, e.busy});
      chk({tag, " pending_o"},    bus_if.pending_o,             e.pend);
      chk({tag, " complete_err"}, {31'd0, bus_if.complete_err}, {31'd0, e.err});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " irq_req"},      {31'd0, bus_if.irq_req},      32'd0);
      chk({tag, " irq_id"},       {27'd0, bus_if.irq_id},       32'd0);
      chk({tag, " busy"},         {31'd0, bus_if.busy},         32'd0);
      chk({tag, " pending_o"},    bus_if.pending_o,             32'd0);
      chk({tag, " complete_err"}, {31'd0, bus_if.complete_err}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      rst_n              = 1'b0;
      bus_if.irq_in      = '0;
      bus_if.irq_enable  = ALL;
      bus_if.irq_edge    = EDG;
      bus_if.claim       = 1'b0;
      bus_if.complete    = 1'b0;
      bus_if.complete_id = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

`ifndef IRQ_SYNC_EN
      //   in            en   clm cmp cid  req id busy pend          err
      add(32'h0,        ALL, 0,  0,  0,   0,  0, 0,   32'h0,        0);
      add(32'h20,       ALL, 0,  0,  0,   0,  0, 0,   32'h20,       0);
      add(32'h0,        ALL, 0,  0,  0,   1,  5, 0,   32'h20,       0);
      add(32'h0,        ALL, 1,  0,  0,   0,  5, 1,   32'h0,        0);
      add(32'h0,        ALL, 0,  0,  0,   0,  5, 1,   32'h0,        0);
      add(32'h0,        ALL, 0,  1,  5,   0,  5, 0,   32'h0,        0);
      add(32'h0,        ALL, 0,  1,  5,   0,  5, 0,   32'h0,        1);
      add(32'h0,        ALL, 0,  0,  0,   0,  5, 0,   32'h0,        0);
      add(32'h208,      ALL, 0,  0,  0,   0,  5, 0,   32'h208,      0);
      add(32'h0,        ALL, 0,  0,  0,   1,  3, 0,   32'h208,      0);
      add(32'h0,        ALL, 1,  0,  0,   0,  3, 1,   32'h200,      0);
      add(32'h0,        ALL, 0,  1,  3,   0,  3, 0,   32'h200,      0);
      add(32'h0,        ALL, 0,  0,  0,   1,  9, 0,   32'h200,      0);
      add(32'h4,        ALL, 0,  0,  0,   1,  9, 0,   32'h204,      0);
      add(32'h0,        ALL, 0,  0,  0,   1,  9, 0,   32'h204,      0);
      add(32'h0,        ALL, 1,  0,  0,   0,  9, 1,   32'h4,        0);
      add(32'h0,        ALL, 0,  1,  9,   0,  9, 0,   32'h4,        0);
      add(32'h0,        ALL, 0,  0,  0,   1,  2, 0,   32'h4,        0);
      add(32'h0,        ALL, 1,  0,  0,   0,  2, 1,   32'h0,        0);
      add(32'h0,        ALL, 0,  1,  7,   0,  2, 1,   32'h0,        1);
      add(32'h0,        ALL, 0,  0,  0,   0,  2, 1,   32'h0,        0);
      add(32'h0,        ALL, 0,  1,  2,   0,  2, 0,   32'h0,        0);
      add(32'h1,        ALL, 0,  0,  0,   0,  2, 0,   32'h1,        0);
      add(32'h1,        ALL, 0,  0,  0,   1,  0, 0,   32'h1,        0);
      add(32'h1,        ALL, 1,  0,  0,   0,  0, 1,   32'h1,        0);
      add(32'h1,        ALL, 0,  1,  0,   0,  0, 0,   32'h1,        0);
      add(32'h1,        ALL, 0,  0,  0,   1,  0, 0,   32'h1,        0);
      add(32'h0,        NO0, 0,  0,  0,   0,  0, 0,   32'h1,        0);
      add(32'h0,        NO0, 0,  0,  0,   0,  0, 0,   32'h1,        0);
      add(32'h0,        ALL, 0,  0,  0,   1,  0, 0,   32'h1,        0);
      add(32'h0,        ALL, 1,  0,  0,   0,  0, 1,   32'h0,        0);
      add(32'h0,        ALL, 0,  1,  0,   0,  0, 0,   32'h0,        0);
      add(32'h0,        ALL, 1,  0,  0,   0,  0, 0,   32'h0,        0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end
`endif

      // Input-to-request latency for an edge pulse on line 5.
      @(negedge clk);
      bus_if.irq_in     = 32'h20;
      bus_if.irq_enable = ALL;
      bus_if.claim      = 1'b0;
      bus_if.complete   = 1'b0;
      got = 0;
      for (int cnt = 1; cnt <= 12; cnt++) begin
         @(posedge clk);
         #1;
         if (bus_if.irq_req) begin
            got = cnt;
            break;
         end
         if (cnt == 1) begin
            @(negedge clk);
            bus_if.irq_in = '0;
         end
      end
      chk("latency cycles", got, 2 + LAT);
      chk("latency irq_id", {27'd0, bus_if.irq_id}, 32'd5);
      apply(mk(32'h0, ALL, 1, 0, 0, 0, 5, 1, 32'h0, 0), "claim5");

      // Reset while in service: outputs clear immediately, without a clock edge.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero("reset_mid_service");
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(32'h0, ALL, 1, 0, 0, 0, 0, 0, 32'h0, 0), "post_reset_claim");
      apply(mk(32'h0, ALL, 0, 1, 5, 0, 0, 0, 32'h0, 1), "post_reset_complete");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
